// File: rtl/usr_access_capture.sv
// Capture stage behind USR_ACCESS: synchronises DATAVALID, qualifies the asynchronous
// DATA word by requiring repeated identical samples, and offers it on a valid/ready port.
module usr_access_capture #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] DATA_IN,
    input  logic        DATAVALID_IN,
    input  logic        CAPTURE_REQ,
    output logic [31:0] DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        BUSY,
    output logic        ERROR,
    output logic [7:0]  CAPTURE_CNT
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   =
        TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_QUALIFY,
        ST_PRESENT
    } state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] dv_sync;
    logic                dv_s;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_p;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                start_pend;

    assign dv_s = dv_sync[SYNC_STAGES-1];

    // DATAVALID synchroniser
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dv_sync <= '0;
        end else begin
            dv_sync <= {dv_sync[SYNC_STAGES-2:0], DATAVALID_IN};
        end
    end

    // Data bus is not synchronised; two consecutive samples feed the stability compare
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_q <= '0;
            data_p <= '0;
        end else begin
            data_q <= DATA_IN;
            data_p <= data_q;
        end
    end

    // Capture sequencer with registered outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= ST_IDLE;
            start_pend  <= 1'b1;
            to_cnt      <= '0;
            stab_cnt    <= '0;
            DOUT        <= '0;
            DOUT_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            ERROR       <= 1'b0;
            CAPTURE_CNT <= '0;
        end else begin
            start_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CAPTURE_REQ || (AUTO_START && start_pend)) begin
                        if (CAPTURE_REQ) begin
                            ERROR <= 1'b0;
                        end
                        to_cnt <= '0;
                        BUSY   <= 1'b1;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dv_s) begin
                        stab_cnt <= '0;
                        state    <= ST_QUALIFY;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
                        ERROR <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_QUALIFY: begin
                    if (!dv_s) begin
                        stab_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= ST_WAIT;
                    end else if (data_q != data_p) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        DOUT       <= data_q;
                        DOUT_VALID <= 1'b1;
                        state      <= ST_PRESENT;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (DOUT_READY) begin
                        DOUT_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                        if (CAPTURE_CNT != CNT_MAX) begin
                            CAPTURE_CNT <= CAPTURE_CNT + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_access_capture.sv
// Bench for usr_access_capture: directed table and sequences plus random traffic
// checked every cycle against a behavioural reference.
module tb_usr_access_capture;

    localparam int unsigned SYNC = 2;
    localparam int unsigned STAB = 4;
    localparam int unsigned TO   = 20;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_QUAL = 2;
    localparam int PH_PRES = 3;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic        DATAVALID_IN = 1'b0;
    logic        CAPTURE_REQ = 1'b0;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY = 1'b0;
    logic        BUSY;
    logic        ERROR;
    logic [7:0]  CAPTURE_CNT;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    usr_access_capture #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .TIMEOUT_CYCLES(TO),
        .AUTO_START    (1'b1)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .DATA_IN     (DATA_IN),
        .DATAVALID_IN(DATAVALID_IN),
        .CAPTURE_REQ (CAPTURE_REQ),
        .DOUT        (DOUT),
        .DOUT_VALID  (DOUT_VALID),
        .DOUT_READY  (DOUT_READY),
        .BUSY        (BUSY),
        .ERROR       (ERROR),
        .CAPTURE_CNT (CAPTURE_CNT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: history of what the block has seen, and which phase of a capture it is in
    int          m_phase = PH_IDLE;
    int          m_wait_cycles = 0;
    int          m_equal_run = 0;
    bit          m_fresh = 1'b1;
    logic [31:0] m_dout = '0;
    logic [31:0] m_newest = '0;
    logic [31:0] m_older = '0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    bit          m_dv_age[SYNC];
    bit          m_dv_seen;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_phase = PH_IDLE;
            m_wait_cycles = 0;
            m_equal_run = 0;
            m_fresh = 1'b1;
            m_dout = '0;
            m_newest = '0;
            m_older = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
            for (int i = 0; i < SYNC; i++) m_dv_age[i] = 1'b0;
        end else begin
            m_dv_seen = m_dv_age[SYNC-1];
            if (m_phase == PH_IDLE) begin
                if (CAPTURE_REQ || m_fresh) begin
                    if (CAPTURE_REQ) m_err = 1'b0;
                    m_phase = PH_WAIT;
                    m_wait_cycles = 0;
                end
            end else if (m_phase == PH_WAIT) begin
                if (m_dv_seen) begin
                    m_phase = PH_QUAL;
                    m_equal_run = 0;
                end else if (m_wait_cycles + 1 == int'(TO)) begin
                    m_err = 1'b1;
                    m_phase = PH_IDLE;
                end else begin
                    m_wait_cycles++;
                end
            end else if (m_phase == PH_QUAL) begin
                if (!m_dv_seen) begin
                    m_phase = PH_WAIT;
                    m_wait_cycles = 0;
                    m_equal_run = 0;
                end else if (m_newest != m_older) begin
                    m_equal_run = 0;
                end else if (m_equal_run + 1 == int'(STAB)) begin
                    m_dout = m_newest;
                    m_valid = 1'b1;
                    m_phase = PH_PRES;
                end else begin
                    m_equal_run++;
                end
            end else begin
                if (DOUT_READY) begin
                    m_valid = 1'b0;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_phase = PH_IDLE;
                end
            end
            m_fresh = 1'b0;
            for (int i = SYNC - 1; i > 0; i--) m_dv_age[i] = m_dv_age[i-1];
            m_dv_age[0] = DATAVALID_IN;
            m_older = m_newest;
            m_newest = DATA_IN;
        end
    end

    always @(negedge CLK) begin
        chk("ref_dout", DOUT, m_dout);
        chk("ref_valid", 32'(DOUT_VALID), 32'(m_valid));
        chk("ref_busy", 32'(BUSY), 32'(m_phase != PH_IDLE));
        chk("ref_error", 32'(ERROR), 32'(m_err));
        chk("ref_cnt", 32'(CAPTURE_CNT), 32'(m_cnt));
    end

    typedef struct {
        logic [31:0] data;
        int          dv_delay;
        int          ready_delay;
        int          exp_lat;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[4];

    // Edges after the DATAVALID sampling edge until DOUT_VALID; caller has just driven DATAVALID_IN=1
    task automatic measure_latency(output int lat);
        @(negedge CLK);
        lat = 0;
        while (!DOUT_VALID && lat < 64) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic handshake(input string name, input logic [7:0] exp_cnt);
        DOUT_READY = 1'b1;
        @(negedge CLK);
        DOUT_READY = 1'b0;
        chk({name, "_cnt"}, 32'(CAPTURE_CNT), 32'(exp_cnt));
        chk({name, "_busy"}, 32'(BUSY), 32'd0);
        chk({name, "_valid"}, 32'(DOUT_VALID), 32'd0);
    endtask

    task automatic pulse_req();
        CAPTURE_REQ = 1'b1;
        @(negedge CLK);
        CAPTURE_REQ = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int bad;
        int w;

        vecs[0] = '{32'hDEAD_BEEF, 0,  0, 6, 8'd2};
        vecs[1] = '{32'h0000_0000, 5,  3, 6, 8'd3};
        vecs[2] = '{32'hFFFF_FFFF, 12, 1, 6, 8'd4};
        vecs[3] = '{32'h1234_5678, 2,  7, 6, 8'd5};

        repeat (3) @(negedge CLK);
        chk("rst_dout", DOUT, 32'd0);
        chk("rst_valid", 32'(DOUT_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_error", 32'(ERROR), 32'd0);
        chk("rst_cnt", 32'(CAPTURE_CNT), 32'd0);

        // Auto-start, DATAVALID arriving 10 cycles after reset release
        DATA_IN = 32'hA5A5_0001;
        RSTN = 1'b1;
        @(negedge CLK);
        chk("auto_start_busy", 32'(BUSY), 32'd1);
        repeat (9) @(negedge CLK);
        DATAVALID_IN = 1'b1;
        measure_latency(lat);
        chk("t1_latency", 32'(lat), 32'd6);
        chk("t1_dout", DOUT, 32'hA5A5_0001);
        handshake("t1", 8'd1);
        DATAVALID_IN = 1'b0;
        repeat (3) @(negedge CLK);

        foreach (vecs[i]) begin
            DATA_IN = vecs[i].data;
            pulse_req();
            chk("vec_busy", 32'(BUSY), 32'd1);
            repeat (vecs[i].dv_delay) @(negedge CLK);
            DATAVALID_IN = 1'b1;
            measure_latency(lat);
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("vec_dout", DOUT, vecs[i].data);
            repeat (vecs[i].ready_delay) @(negedge CLK);
            chk("vec_hold_valid", 32'(DOUT_VALID), 32'd1);
            handshake("vec", vecs[i].exp_cnt);
            DATAVALID_IN = 1'b0;
            repeat (3) @(negedge CLK);
        end

        // Toggling data never qualifies; settling value captured 4 cycles after first equal pair
        DATA_IN = 32'h1;
        DATAVALID_IN = 1'b1;
        pulse_req();
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            DATA_IN = ((i / 2) % 2 == 1) ? 32'h2 : 32'h1;
            @(negedge CLK);
            if (DOUT_VALID) bad++;
        end
        chk("toggle_no_valid", 32'(bad), 32'd0);
        DATA_IN = 32'h2;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("toggle_settle_valid", 32'(DOUT_VALID), (k == 6) ? 32'd1 : 32'd0);
        end
        chk("toggle_dout", DOUT, 32'h2);
        handshake("toggle", 8'd6);
        DATAVALID_IN = 1'b0;
        repeat (3) @(negedge CLK);

        // DATAVALID drops after two stable samples, re-rises 5 cycles later
        DATA_IN = 32'h0BAD_F00D;
        pulse_req();
        DATAVALID_IN = 1'b1;
        repeat (3) @(negedge CLK);
        DATAVALID_IN = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("drop_valid", 32'(DOUT_VALID), 32'd0);
            chk("drop_busy", 32'(BUSY), 32'd1);
        end
        DATAVALID_IN = 1'b1;
        measure_latency(lat);
        chk("drop_latency", 32'(lat), 32'd6);
        chk("drop_dout", DOUT, 32'h0BAD_F00D);
        handshake("drop", 8'd7);
        DATAVALID_IN = 1'b0;
        repeat (3) @(negedge CLK);

        // Timeout after 20 WAIT cycles, cleared by a new request
        pulse_req();
        chk("to_start_busy", 32'(BUSY), 32'd1);
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge CLK);
            if (ERROR || !BUSY) bad++;
        end
        chk("to_early", 32'(bad), 32'd0);
        @(negedge CLK);
        chk("to_error", 32'(ERROR), 32'd1);
        chk("to_busy", 32'(BUSY), 32'd0);
        repeat (4) @(negedge CLK);
        chk("to_sticky", 32'(ERROR), 32'd1);
        DATA_IN = 32'hC0FF_EE00;
        pulse_req();
        chk("to_clear_error", 32'(ERROR), 32'd0);
        chk("to_clear_busy", 32'(BUSY), 32'd1);
        DATAVALID_IN = 1'b1;
        measure_latency(lat);
        chk("to_latency", 32'(lat), 32'd6);
        handshake("to", 8'd8);
        DATAVALID_IN = 1'b0;
        repeat (3) @(negedge CLK);

        // PRESENT held for 50 cycles with a stray request and a data change
        DATA_IN = 32'h5555_AAAA;
        DATAVALID_IN = 1'b1;
        pulse_req();
        measure_latency(lat);
        chk("hold_reach", 32'(DOUT_VALID), 32'd1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            CAPTURE_REQ = (i == 10);
            if (i == 20) DATA_IN = 32'h3333_CCCC;
            @(negedge CLK);
            if (DOUT !== 32'h5555_AAAA || DOUT_VALID !== 1'b1 || BUSY !== 1'b1) bad++;
        end
        CAPTURE_REQ = 1'b0;
        chk("hold_stable", 32'(bad), 32'd0);
        DOUT_READY = 1'b1;
        @(negedge CLK);
        chk("hold_hs_cnt", 32'(CAPTURE_CNT), 32'd9);
        chk("hold_hs_valid", 32'(DOUT_VALID), 32'd0);
        chk("hold_dout_kept", DOUT, 32'h5555_AAAA);
        repeat (3) @(negedge CLK);
        DOUT_READY = 1'b0;
        chk("hold_once_cnt", 32'(CAPTURE_CNT), 32'd9);
        chk("hold_once_busy", 32'(BUSY), 32'd0);

        // Asynchronous reset while presenting
        DATA_IN = 32'h7777_0001;
        pulse_req();
        measure_latency(lat);
        chk("arst_pre_valid", 32'(DOUT_VALID), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_dout", DOUT, 32'd0);
        chk("arst_valid", 32'(DOUT_VALID), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_error", 32'(ERROR), 32'd0);
        chk("arst_cnt", 32'(CAPTURE_CNT), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // 256 captures; counter saturates
        for (int n = 1; n <= 256; n++) begin
            if (n > 1) pulse_req();
            w = 0;
            while (!DOUT_VALID && w < 64) begin
                @(negedge CLK);
                w++;
            end
            chk("sat_valid", 32'(DOUT_VALID), 32'd1);
            DOUT_READY = 1'b1;
            @(negedge CLK);
            DOUT_READY = 1'b0;
            if (n == 1 || n >= 255) chk("sat_cnt", 32'(CAPTURE_CNT), 32'((n > 255) ? 255 : n));
        end
        DATAVALID_IN = 1'b0;
        repeat (3) @(negedge CLK);

        // Random traffic, checked every cycle against the reference
        for (int c = 0; c < 3000; c++) begin
            CAPTURE_REQ = ($urandom_range(0, 15) == 0);
            DOUT_READY = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) DATAVALID_IN = ~DATAVALID_IN;
            if ($urandom_range(0, 7) == 0) DATA_IN = 32'($urandom_range(0, 3)) << 28;
            @(negedge CLK);
        end
        CAPTURE_REQ = 1'b0;
        DOUT_READY = 1'b0;
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
